video_position_tracker: RTL and testbench

VIDEO_POSITION_TRACKER -- requirements
Module: video_position_tracker

---
 rtl/video_position_tracker.sv | 113 +++++++++++
 tb/tb_video_position_tracker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/video_position_tracker.sv
// video_position_tracker: tracks line/dot position of the visible pixel within a video field.
// Define VIDEO_POSITION_TRACKER_FIELD_PARITY_EN to enable the toggling fieldParity output.
module video_position_tracker #(
   parameter int DOTS_PER_LINE    = 720,
   parameter int LINES_PER_FIELD  = 288,
   parameter int DOT_WIDTH        = 10,
   parameter int LINE_WIDTH       = 10,
   parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
   input  logic                  pixelClockX6,
   input  logic                  nReset,
   input  logic                  pixelClockX1_en,
   input  logic                  displayEnabled,
   input  logic                  vSync,
   output logic [LINE_WIDTH-1:0] fieldLine,
   output logic [DOT_WIDTH-1:0]  fieldLineDot,
   output logic                  posValid,
   output logic                  lineStart,
   output logic                  fieldStart,
   output logic                  overrun,
   output logic                  fieldParity
);
   localparam logic [DOT_WIDTH-1:0]  DOT_MAX  = DOT_WIDTH'(DOTS_PER_LINE - 1);
   localparam logic [LINE_WIDTH-1:0] LINE_MAX = LINE_WIDTH'(LINES_PER_FIELD - 1);

   typedef enum logic [1:0] {SYNC_WAIT, ACTIVE, BLANK} state_t;

   state_t                  state, state_nxt;
   logic                    vs_act, vs_prev, vs_edge;
   logic                    line_full, line_full_nxt;
   logic [LINE_WIDTH-1:0]   line_nxt;
   logic [DOT_WIDTH-1:0]    dot_nxt;
   logic                    pos_valid_nxt, line_start_nxt, overrun_nxt;

   assign vs_act  = VSYNC_ACTIVE_LOW ? ~vSync : vSync;
   assign vs_edge = vs_act & ~vs_prev;

   always_ff @(posedge pixelClockX6 or negedge nReset)
      if (!nReset)
         state <= SYNC_WAIT;
      else if (pixelClockX1_en)
         state <= state_nxt;

   always_comb
      state_nxt = vs_act                              ? BLANK  :
                  (state == BLANK  &&  displayEnabled) ? ACTIVE :
                  (state == ACTIVE && !displayEnabled) ? BLANK  : state;

   // line_full marks that the last permitted line has ended; only a further line counts as overrun
   always_comb begin
      line_nxt       = fieldLine;
      dot_nxt        = fieldLineDot;
      pos_valid_nxt  = 1'b0;
      line_start_nxt = 1'b0;
      overrun_nxt    = overrun;
      line_full_nxt  = line_full;
      if (vs_act) begin
         line_nxt      = '0;
         dot_nxt       = '0;
         overrun_nxt   = 1'b0;
         line_full_nxt = 1'b0;
      end else if (state == BLANK && displayEnabled) begin
         dot_nxt        = '0;
         pos_valid_nxt  = ~line_full;
         line_start_nxt = ~line_full;
         overrun_nxt    = overrun | line_full;
      end else if (state == ACTIVE && displayEnabled) begin
         if (fieldLineDot == DOT_MAX)
            overrun_nxt = 1'b1;
         else begin
            dot_nxt       = fieldLineDot + 1'b1;
            pos_valid_nxt = ~line_full;
         end
      end else if (state == ACTIVE) begin
         dot_nxt = '0;
         if (fieldLine == LINE_MAX)
            line_full_nxt = 1'b1;
         else
            line_nxt = fieldLine + 1'b1;
      end
   end

   always_ff @(posedge pixelClockX6 or negedge nReset)
      if (!nReset) begin
         vs_prev      <= 1'b0;
         fieldLine    <= '0;
         fieldLineDot <= '0;
         posValid     <= 1'b0;
         lineStart    <= 1'b0;
         fieldStart   <= 1'b0;
         overrun      <= 1'b0;
         line_full    <= 1'b0;
      end else if (pixelClockX1_en) begin
         vs_prev      <= vs_act;
         fieldLine    <= line_nxt;
         fieldLineDot <= dot_nxt;
         posValid     <= pos_valid_nxt;
         lineStart    <= line_start_nxt;
         fieldStart   <= vs_edge;
         overrun      <= overrun_nxt;
         line_full    <= line_full_nxt;
      end

`ifdef VIDEO_POSITION_TRACKER_FIELD_PARITY_EN
   always_ff @(posedge pixelClockX6 or negedge nReset)
      if (!nReset)
         fieldParity <= 1'b0;
      else if (pixelClockX1_en && vs_edge)
         fieldParity <= ~fieldParity;
`else
   assign fieldParity = 1'b0;
`endif
endmodule

// File: tb/tb_video_position_tracker.sv
// tb_video_position_tracker: directed and randomized checks of video_position_tracker against a
// run-length based reference model, using small line/field sizes to keep runs short.
module tb_video_position_tracker;
   localparam int D  = 20;
   localparam int L  = 8;
   localparam int DW = 5;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          nReset = 1'b0;
   logic          en = 1'b0;
   logic          de = 1'b0;
   logic          vsync_n = 1'b1;
   logic [LW-1:0] field_line;
   logic [DW-1:0] field_dot;
   logic          pos_valid, line_start, field_start, overrun, field_parity;

   video_position_tracker #(
      .DOTS_PER_LINE(D), .LINES_PER_FIELD(L), .DOT_WIDTH(DW), .LINE_WIDTH(LW), .VSYNC_ACTIVE_LOW(1'b1)
   ) dut (
      .pixelClockX6(clk), .nReset(nReset), .pixelClockX1_en(en), .displayEnabled(de), .vSync(vsync_n),
      .fieldLine(field_line), .fieldLineDot(field_dot), .posValid(pos_valid), .lineStart(line_start),
      .fieldStart(field_start), .overrun(overrun), .fieldParity(field_parity)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ls_cnt = 0;
   int fs_cnt = 0;

   // reference model: position derived from length of the current run of visible dots and lines completed
   bit synced, prev_vs, m_over, m_par;
   int run_len, lines_done;
   int e_line, e_dot;
   bit e_pv, e_ls, e_fs;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      synced = 0; prev_vs = 0; m_over = 0; m_par = 0; run_len = 0; lines_done = 0;
      e_line = 0; e_dot = 0; e_pv = 0; e_ls = 0; e_fs = 0;
   endtask

   task automatic model(input bit d, input bit vs);
      int k;
      e_fs = vs && !prev_vs;
      e_ls = 0;
      e_pv = 0;
      if (vs) begin
         synced = 1; run_len = 0; lines_done = 0; m_over = 0;
         e_line = 0; e_dot = 0;
         if (e_fs) m_par = ~m_par;
      end else if (!synced) begin
         e_line = 0; e_dot = 0;
      end else if (d) begin
         k = run_len;
         run_len++;
         e_dot = (k < D) ? k : D - 1;
         e_pv = (k < D) && (lines_done < L);
         e_ls = (k == 0) && (lines_done < L);
         if (!e_pv) m_over = 1;
         e_line = (lines_done < L) ? lines_done : L - 1;
      end else begin
         if (run_len > 0) lines_done++;
         run_len = 0;
         e_dot = 0;
         e_line = (lines_done < L) ? lines_done : L - 1;
      end
      prev_vs = vs;
   endtask

   // one pixel-rate step: five disabled clocks with input noise, then one enabled clock
   task automatic step(input bit d, input bit vs);
      bit exp_par;
      repeat (5) begin
         @(negedge clk);
         en = 1'b0; de = 1'($urandom); vsync_n = 1'($urandom);
      end
      @(negedge clk);
      en = 1'b1; de = d; vsync_n = ~vs;
      @(posedge clk);
      #1;
      en = 1'b0;
      model(d, vs);
`ifdef VIDEO_POSITION_TRACKER_FIELD_PARITY_EN
      exp_par = m_par;
`else
      exp_par = 1'b0;
`endif
      ls_cnt += int'(line_start);
      fs_cnt += int'(field_start);
      chk("line", 32'(field_line), 32'(e_line));
      chk("dot", 32'(field_dot), 32'(e_dot));
      chk("pos_valid", 32'(pos_valid), 32'(e_pv));
      chk("line_start", 32'(line_start), 32'(e_ls));
      chk("field_start", 32'(field_start), 32'(e_fs));
      chk("overrun", 32'(overrun), 32'(m_over));
      chk("parity", 32'(field_parity), 32'(exp_par));
   endtask

   task automatic line(input int n, input int blank);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0);
      for (int i = 0; i < blank; i++) step(1'b0, 1'b0);
   endtask

   task automatic vs_pulse();
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      nReset = 1'b0;
      #1;
      model_reset();
      chk("rst_line", 32'(field_line), 0);
      chk("rst_dot", 32'(field_dot), 0);
      chk("rst_flags", {26'd0, pos_valid, line_start, field_start, overrun, field_parity}, 0);
      repeat (3) @(negedge clk);
      nReset = 1'b1;
   endtask

   initial begin
      model_reset();
      pulse_reset();
      line(10, 2);
      line(D, 2);
      chk("pre_sync_overrun", 32'(overrun), 0);

      ls_cnt = 0;
      fs_cnt = 0;
      vs_pulse();
      for (int l = 0; l < L; l++) line(D, 3);
      chk("field_ls_count", ls_cnt, L);
      chk("field_fs_count", fs_cnt, 1);
      chk("field_final_line", 32'(field_line), L - 1);
      chk("field_no_overrun", 32'(overrun), 0);

      vs_pulse();
      line(D + 5, 2);
      chk("long_overrun", 32'(overrun), 1);
      line(D, 2);
      chk("long_overrun_sticky", 32'(overrun), 1);
      vs_pulse();
      chk("overrun_cleared", 32'(overrun), 0);

      line(7, 2);
      chk("short_line_adv", 32'(field_line), 1);
      line(D, 2);
      chk("after_short_line", 32'(field_line), 2);

      vs_pulse();
      for (int l = 0; l < 5; l++) line(D, 2);
      line(10, 0);
      step(1'b1, 1'b1);
      chk("mid_vs_fs", 32'(field_start), 1);
      step(1'b1, 1'b1);
      chk("held_vs_pv", 32'(pos_valid), 0);
      step(1'b1, 1'b0);
      chk("post_vs_ls", 32'(line_start), 1);
      line(D - 1, 2);

      vs_pulse();
      for (int l = 0; l < L + 2; l++) line(D, 2);
      chk("line_overflow", 32'(overrun), 1);
      chk("line_saturated", 32'(field_line), L - 1);

      vs_pulse();
      line(D, 2);
      line(5, 0);
      pulse_reset();
      line(D, 2);
      chk("post_reset_pv", 32'(pos_valid), 0);
      vs_pulse();
      line(D, 2);

      for (int it = 0; it < 220; it++) begin
         if ($urandom_range(0, 9) == 0) begin
            for (int j = $urandom_range(1, 3); j > 0; j--) step(1'($urandom), 1'b1);
         end else if ($urandom_range(0, 39) == 0) begin
            line($urandom_range(1, D), 0);
            pulse_reset();
         end else begin
            line($urandom_range(1, D + 4), $urandom_range(1, 3));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
